data_bus_ctrl: RTL

Memory-side slave of the CPU core's data bus (db_*). It accepts one fetch, load or store at a time and checks alignment. It decodes the address into on-chip RAM, an IO window or a hole, and drives a synchronous SRAM port or a handshaked IO port. It returns a one-cycle db_ready pulse with lane-aligned read data, plus db_error for faults.

---
 rtl/data_bus_ctrl_pkg.sv | 21 ++
 rtl/data_bus_ctrl_lane_align.sv | 36 +++
 rtl/data_bus_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/data_bus_ctrl_pkg.sv
// Shared encodings for the CPU data bus slave: access/len codes and controller states.
package data_bus_ctrl_pkg;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_R    = 2'd1;
  localparam logic [1:0] ACC_W    = 2'd2;
  localparam logic [1:0] ACC_X    = 2'd3;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RAM  = 3'd1,
    S_IO   = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/data_bus_ctrl_lane_align.sv
// Byte-lane helper: byte enables, write-data replication, read-data shift, misalign flag.
module data_bus_ctrl_lane_align
  import data_bus_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_shifted,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    misaligned = |off;
    case (len)
      LEN_B: begin
        be         = 4'b0001 << off;
        wdata_rep  = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      LEN_H: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = off[0];
      end
      default: ;
    endcase
  end

  assign rdata_shifted = rdata >> {off, 3'b000};

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-bus slave: decodes RAM / IO / hole, drives SRAM or handshaked IO, returns one-cycle ready.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter int          RAM_AW     = 16,
  parameter int          RAM_WAIT   = 1,
  parameter logic [31:0] IO_BASE    = 32'h1F000000,
  parameter int          IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              res,
  input  logic [31:0]       db_addr,
  input  logic [1:0]        db_accessType,
  input  logic [1:0]        db_memLen,
  input  logic [31:0]       db_wdata,
  output logic [31:0]       db_rdata,
  output logic              db_ready,
  output logic              db_error,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_re,
  output logic              io_we,
  output logic [15:0]       io_addr,
  output logic [31:0]       io_wdata,
  output logic [3:0]        io_be,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  a_off;
  logic        a_write;

  logic [31:0] pa;
  logic        in_ram, in_io, unused_addr;
  assign pa          = {3'b000, db_addr[28:0]};
  assign in_ram      = {32'b0, pa} < (64'd4 << RAM_AW);
  assign in_io       = pa[31:16] == IO_BASE[31:16];
  assign unused_addr = ^db_addr[31:29];

  // Aligner sees the live request in IDLE and the latched lane offset afterwards.
  logic [1:0]  al_off;
  logic [31:0] al_rdata, al_wrep, al_rsh;
  logic [3:0]  al_be;
  logic        al_mis;
  assign al_off   = (state == S_IDLE) ? db_addr[1:0] : a_off;
  assign al_rdata = (state == S_IO) ? io_rdata : mem_rdata;

  data_bus_ctrl_lane_align u_align (
    .off(al_off), .len(db_memLen), .wdata(db_wdata), .rdata(al_rdata),
    .be(al_be), .wdata_rep(al_wrep), .rdata_shifted(al_rsh), .misaligned(al_mis)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_IDLE; cnt <= '0; a_off <= '0; a_write <= 1'b0;
      db_rdata <= '0; db_ready <= 1'b0; db_error <= 1'b0;
      mem_en <= 1'b0; mem_we <= 1'b0; mem_be <= '0; mem_addr <= '0; mem_wdata <= '0;
      io_re <= 1'b0; io_we <= 1'b0; io_addr <= '0; io_wdata <= '0; io_be <= '0;
    end else begin
      db_ready <= 1'b0;
      db_error <= 1'b0;
      case (state)
        S_IDLE: if (db_accessType != ACC_NONE) begin
          a_off   <= db_addr[1:0];
          a_write <= (db_accessType == ACC_W);
          cnt     <= '0;
          if (al_mis || !(in_ram || in_io) || (in_io && db_accessType == ACC_X)) begin
            state <= S_ERR; db_ready <= 1'b1; db_error <= 1'b1;
          end else if (in_ram) begin
            state     <= S_RAM;
            mem_en    <= 1'b1;
            mem_we    <= (db_accessType == ACC_W);
            mem_be    <= al_be;
            mem_addr  <= pa[RAM_AW+1:2];
            mem_wdata <= al_wrep;
          end else begin
            state    <= S_IO;
            io_re    <= (db_accessType != ACC_W);
            io_we    <= (db_accessType == ACC_W);
            io_be    <= al_be;
            io_addr  <= pa[15:0];
            io_wdata <= al_wrep;
          end
        end
        S_RAM: if (cnt == 16'(RAM_WAIT)) begin
          if (!a_write) db_rdata <= al_rsh;
          mem_en <= 1'b0; mem_we <= 1'b0;
          state <= S_RESP; db_ready <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
        // io_ack outranks the timeout when both land in the same cycle.
        S_IO: if (io_ack) begin
          if (!a_write) db_rdata <= al_rsh;
          io_re <= 1'b0; io_we <= 1'b0;
          state <= S_RESP; db_ready <= 1'b1;
        end else if (cnt == 16'(IO_TIMEOUT)) begin
          io_re <= 1'b0; io_we <= 1'b0;
          state <= S_ERR; db_ready <= 1'b1; db_error <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
